// File: rtl/distribute_dst_tag_inject_seq.sv
// ---------------------------------------------------------------------------
// distribute_dst_tag_inject_seq
//
// Small FIFO that sits in front of a 1xN binary distribute tree. Each entry
// pairs a payload with a destination tag. The tag of the oldest entry drives
// the tree root command (consumed MSB-first by the 1x2 stages below).
//
// Parameters
//   DATA_WIDTH             payload width
//   DESTINATION_TAG_WIDTH  tag width
//   FIFO_DEPTH             entry count, power of two, >= 2
//
// Optional feature (compile-time macro DST_TAG_AUTO_INC_EN)
//   defined   : i_dst_tag is ignored; the stored tag comes from an internal
//               counter that starts at 0 and steps by one per push, wrapping
//               naturally, giving round-robin distribution over the leaves.
//   undefined : the stored tag is i_dst_tag sampled at push (default).
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid      upstream payload valid
//   i_data_bus   upstream payload
//   i_dst_tag    upstream destination tag
//   o_ready      buffer can accept a payload (low during reset and when full)
//   o_valid      head entry valid towards the tree root
//   o_data_bus   head payload, all-z when empty
//   o_cmd        head destination tag (tree root command), all-z when empty
//   o_en         tree enable, equal to o_valid
//   i_ready      downstream accepts the head this cycle
//   o_occupancy  number of stored entries, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module distribute_dst_tag_inject_seq #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned DESTINATION_TAG_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH            = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  input  logic [DATA_WIDTH-1:0]            i_data_bus,
  input  logic [DESTINATION_TAG_WIDTH-1:0] i_dst_tag,
  output logic                             o_ready,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data_bus,
  output logic [DESTINATION_TAG_WIDTH-1:0] o_cmd,
  output logic                             o_en,
  input  logic                             i_ready,
  output logic [$clog2(FIFO_DEPTH):0]      o_occupancy
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;
  localparam int unsigned TAG_W   = DESTINATION_TAG_WIDTH;
  localparam int unsigned ENTRY_W = TAG_W + DATA_WIDTH;

  // Storage; contents are don't-care until written, so no reset.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  // State registers and their next values.
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [OCC_W-1:0] occ,    occ_nxt;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [TAG_W-1:0] tag_sel;
  logic [ENTRY_W-1:0] head;

  // Status decode from the registered count.
  assign full  = (occ == OCC_W'(FIFO_DEPTH));
  assign empty = (occ == OCC_W'(0));

  // rst_n gates ready so nothing is accepted while reset is asserted.
  assign o_ready = rst_n & ~full;
  assign o_valid = ~empty;
  assign o_en    = o_valid;

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

`ifdef DST_TAG_AUTO_INC_EN
  // Round-robin tag source; advances only on accepted pushes.
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] tag_cnt_nxt;
  logic             unused_dst_tag;

  assign unused_dst_tag = ^i_dst_tag;

  always_comb begin
    tag_cnt_nxt = tag_cnt;
    if (push) begin
      tag_cnt_nxt = tag_cnt + TAG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= '0;
    end else begin
      tag_cnt <= tag_cnt_nxt;
    end
  end

  assign tag_sel = tag_cnt;
`else
  // Tag is taken from the upstream side at push time.
  assign tag_sel = i_dst_tag;
`endif

  // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occ;
    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      occ    <= occ_nxt;
    end
  end

  // Entry write keeps tag and payload together in one word.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {tag_sel, i_data_bus};
    end
  end

  // Head presentation; bus floats when there is nothing to show.
  assign head        = mem[rd_ptr];
  assign o_data_bus  = o_valid ? head[DATA_WIDTH-1:0]       : {DATA_WIDTH{1'bz}};
  assign o_cmd       = o_valid ? head[ENTRY_W-1:DATA_WIDTH] : {TAG_W{1'bz}};
  assign o_occupancy = occ;

endmodule

// File: tb/tb_distribute_dst_tag_inject_seq.sv
module tb_distribute_dst_tag_inject_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data_bus;
  logic [2:0]  i_dst_tag;
  logic        i_ready;
  wire         o_ready;
  wire         o_valid;
  wire  [31:0] o_data_bus;
  wire  [2:0]  o_cmd;
  wire         o_en;
  wire  [2:0]  o_occupancy;

  int checks;
  int failures;

  // Reference model: queue of {tag, data}, plus the auto tag counter.
  logic [34:0] q[$];
  int          mcnt;
  logic [31:0] z32;
  logic [2:0]  z3;

  distribute_dst_tag_inject_seq #(
    .DATA_WIDTH(32), .DESTINATION_TAG_WIDTH(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_data_bus(i_data_bus), .i_dst_tag(i_dst_tag),
    .o_ready(o_ready), .o_valid(o_valid), .o_data_bus(o_data_bus),
    .o_cmd(o_cmd), .o_en(o_en), .i_ready(i_ready), .o_occupancy(o_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_tag(input logic [2:0] t);
`ifdef DST_TAG_AUTO_INC_EN
    return 3'(mcnt);
`else
    return t;
`endif
  endfunction

  // One clock edge with the model updated from the driven inputs.
  task automatic tick();
    bit          do_pop;
    bit          do_push;
    logic [34:0] ent;
    do_pop  = (q.size() > 0) && i_ready;
    do_push = i_valid && (q.size() < 4);
    ent     = {exp_tag(i_dst_tag), i_data_bus};
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(ent);
      mcnt++;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] t, input logic r);
    i_valid    = v;
    i_data_bus = d;
    i_dst_tag  = t;
    i_ready    = r;
  endtask

  // Compare all observable outputs against the model (reset released).
  task automatic check_head(input string tag);
    logic [34:0] h;
    if (q.size() > 0) begin
      h = q[0];
      check({tag, ".valid"}, 64'(o_valid), 64'(1));
      check({tag, ".data"},  64'(o_data_bus), 64'(h[31:0]));
      check({tag, ".cmd"},   64'(o_cmd), 64'(h[34:32]));
    end else begin
      check({tag, ".valid"}, 64'(o_valid), 64'(0));
      check({tag, ".dataz"}, 64'(o_data_bus), 64'(z32));
      check({tag, ".cmdz"},  64'(o_cmd), 64'(z3));
    end
    check({tag, ".en"},    64'(o_en), 64'(o_valid));
    check({tag, ".occ"},   64'(o_occupancy), 64'(q.size()));
    check({tag, ".ready"}, 64'(o_ready), 64'(q.size() != 4));
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, ".valid"}, 64'(o_valid), 64'(0));
    check({tag, ".en"},    64'(o_en), 64'(0));
    check({tag, ".ready"}, 64'(o_ready), 64'(0));
    check({tag, ".occ"},   64'(o_occupancy), 64'(0));
    check({tag, ".dataz"}, 64'(o_data_bus), 64'(z32));
    check({tag, ".cmdz"},  64'(o_cmd), 64'(z3));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mcnt     = 0;
    z32      = 'z;
    z3       = 'z;
    rst_n    = 1'b0;
    drive(1'b0, 32'h0, 3'h0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check_in_reset("rst");
    rst_n = 1'b1;
    #1;
    check("rst_rel.ready", 64'(o_ready), 64'(1));
    check_head("rst_rel");

    // Single push into empty, held while i_ready=0, then popped.
    drive(1'b1, 32'hA5A5_0001, 3'b101, 1'b0);
    tick();
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check("single.data", 64'(o_data_bus), 64'h0000_0000_A5A5_0001);
`ifdef DST_TAG_AUTO_INC_EN
    check("single.cmd", 64'(o_cmd), 64'(0));
`else
    check("single.cmd", 64'(o_cmd), 64'(3'b101));
`endif
    check_head("single");
    tick();
    tick();
    check_head("single_hold");
    drive(1'b0, 32'h0, 3'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check_head("single_pop");

    // Fill: five pushes, the fifth must be dropped.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 3'(i), 1'b0);
      tick();
      check("fill.ready", 64'(o_ready), 64'(i < 4));
    end
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check("fill.occ", 64'(o_occupancy), 64'(4));
    check_head("full");
    for (int i = 1; i <= 4; i++) begin
      check("drain.data", 64'(o_data_bus), 64'(i));
      drive(1'b0, 32'h0, 3'h0, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check_head("drained");

    // Simultaneous push/pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 3'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      check("pp.head", 64'(o_data_bus), 64'(32'h100 + 32'(i)));
      drive(1'b1, 32'h102 + 32'(i), 3'(i + 2), 1'b1);
      tick();
      check("pp.occ", 64'(o_occupancy), 64'(2));
      check_head("pp");
    end
    for (int i = 10; i < 12; i++) begin
      check("pp_drain.data", 64'(o_data_bus), 64'(32'h100 + 32'(i)));
      drive(1'b0, 32'h0, 3'h0, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check_head("pp_end");

    // Asynchronous reset with three entries stored.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD_0000 + 32'(i), 3'(i), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check("pre_rst.occ", 64'(o_occupancy), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset("mid_rst");
    q.delete();
    mcnt = 0;
    @(posedge clk);
    #3;
    check_in_reset("mid_rst_hold");
    rst_n = 1'b1;
    #1;
    check("post_rst.ready", 64'(o_ready), 64'(1));
    tick();
    check_head("post_rst");

    // Ten pushes with tag 7 streaming through at occupancy 1.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 3'b111, 1'b1);
      tick();
`ifdef DST_TAG_AUTO_INC_EN
      check("tag.cmd", 64'(o_cmd), 64'(3'(i)));
`else
      check("tag.cmd", 64'(o_cmd), 64'(3'b111));
`endif
      check("tag.data", 64'(o_data_bus), 64'(32'h200 + 32'(i)));
      check("tag.occ", 64'(o_occupancy), 64'(1));
    end
    drive(1'b0, 32'h0, 3'h0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 3'h0, 1'b0);
    check_head("tag_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
